sp16k_arbiter: RTL and testbench
================================

SP16K_ARBITER -- requirements
Module: sp16k_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the address width of both requesters and the RAM port.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width of both requesters and the RAM port.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rN_req  in  1  requester N (N=0,1) access request; held with fields stable until granted.
REQ-006 rN_we  in  1  requester N write enable (1=write, 0=read).
REQ-007 rN_addr  in  ADDR_W  requester N address.
REQ-008 rN_wdata  in  DATA_W  requester N write data.
REQ-009 rN_gnt  out  1  requester N accepted this cycle (combinational).
REQ-010 rN_rvalid  out  1  requester N read data valid (registered pulse).
REQ-011 rN_rdata  out  DATA_W  requester N read data; meaningful only while rN_rvalid=1.
REQ-012 ram_ce, ram_oce, ram_wre  out  1 each  single-port RAM controls.
REQ-013 ram_reset  out  1  RAM output-latch reset.
REQ-014 ram_ad  out  ADDR_W; ram_din  out  DATA_W; ram_dout  in  DATA_W  RAM address/data.

Function
REQ-015 At most one of r0_gnt/r1_gnt SHALL be 1 in any cycle; rN_gnt=1 only if rN_req=1 and reset=0.
REQ-016 In a grant cycle, ram_ce=1, ram_wre=granted rN_we, and ram_ad/ram_din SHALL equal the granted requester's addr/wdata; with no grant, ram_ce=0 and ram_wre=0.
REQ-017 ram_oce SHALL be tied to 1 (RAM in bypass read mode, 1-cycle read latency).
REQ-018 A granted read SHALL produce rN_rvalid=1 for exactly one cycle, in the cycle after grant, with rN_rdata=ram_dout; granted writes SHALL produce no rvalid.
REQ-019 Both rN_rdata outputs SHALL be driven from ram_dout; only rvalid distinguishes the owner.
REQ-020 Throughput SHALL be one access per cycle; a requester holding req after gnt SHALL be eligible again in the next cycle.
REQ-021 Single requester active: granted in the same cycle, no idle cycle inserted.
REQ-022 Both requesting: winner per REQ-030/031; loser waits with req held and receives no gnt that cycle.
REQ-023 A read followed by a write to the same address in consecutive cycles SHALL return pre-write data for the read.
REQ-024 Address wrap: ADDR_W-bit addresses SHALL pass unmodified; no range checking.
REQ-025 Internal state: last-granted pointer (1 bit) and read-tag register (valid + owner, 2 bits).

Reset
REQ-026 While reset=1: rN_gnt=0, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
REQ-027 In the cycle after reset is sampled high: rN_rvalid=0, read tag cleared, last-granted pointer=1 (requester 0 wins first tie).
REQ-028 ram_reset SHALL equal reset.
REQ-029 Reset asserted in the cycle after a read grant SHALL cancel that rvalid.

Configuration
REQ-030 With macro SP16K_ARB_RR_EN defined: round-robin; on a tie the requester not granted last wins; pointer updates on every grant.
REQ-031 Without SP16K_ARB_RR_EN: fixed priority, requester 0 always wins ties; pointer register SHALL not be present.

Structure
REQ-032 Package sp16k_arb_pkg SHALL hold ADDR_W/DATA_W default constants, the requester-index typedef and the read-tag struct typedef.
REQ-033 Sub-module sp16k_arb_pick (combinational winner selection from req vector and pointer) SHALL contain the arbitration decision; sp16k_arbiter holds all registers and muxing.

Verification
REQ-034 r0 write 0x0123<-0xA5, then r0 read 0x0123 -> r0_gnt each cycle, r0_rvalid next cycle after read with r0_rdata=0xA5.
REQ-035 r0 and r1 both read continuously for 4 cycles (RR build) -> grants 0,1,0,1; rvalid owners follow one cycle later.
REQ-036 Same stimulus, macro undefined -> r0_gnt all 4 cycles, r1_gnt=0 until r0_req drops.
REQ-037 r1 read 0x3FFF (holds 0x5A) then r0 write 0x3FFF<-0xFF next cycle -> r1_rdata=0x5A; later read returns 0xFF.
REQ-038 Reset asserted cycle after r1 read grant -> r1_rvalid=0, ram_ce=0; first tie after reset granted to r0.

Source files
------------

// File: rtl/sp16k_arb_pkg.sv
// Shared constants and types for the two-requester SP16K RAM arbiter.
package sp16k_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    typedef logic req_idx_t;

    // Remembers which requester owns the read data returning next cycle.
    typedef struct packed {
        logic     valid;
        req_idx_t owner;
    } rd_tag_t;

endpackage

// File: rtl/sp16k_arbiter_if.sv
// One requester port of the SP16K arbiter: request fields in, grant and read return out.
interface sp16k_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sp16k_arb_pick.sv
// Combinational winner selection; on a tie the requester not granted last wins.
module sp16k_arb_pick
    import sp16k_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic       gnt_any,
    output req_idx_t   win
);

    always_comb begin
        gnt_any = |req;
        win     = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
    end

endmodule

// File: rtl/sp16k_arbiter.sv
// Two-requester arbiter for a single-port SP16K RAM in bypass read mode (1-cycle latency).
// Define SP16K_ARB_RR_EN for round-robin ties; otherwise requester 0 has fixed priority.
module sp16k_arbiter
    import sp16k_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    sp16k_arbiter_if.slave    r0,
    sp16k_arbiter_if.slave    r1,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [1:0] req_v;
    logic       gnt_any;
    req_idx_t   win;
    req_idx_t   last_sel;
    logic       we_sel;
    rd_tag_t    tag_d, tag_q;

    // Reset masks requests so no grant can leak out while it is held.
    assign req_v = reset ? 2'b00 : {r1.req, r0.req};

    sp16k_arb_pick u_pick (
        .req     (req_v),
        .last    (last_sel),
        .gnt_any (gnt_any),
        .win     (win)
    );

`ifdef SP16K_ARB_RR_EN
    req_idx_t last_d, last_q;

    assign last_sel = last_q;

    always_comb begin
        last_d = last_q;
        if (gnt_any) last_d = win;
    end
`else
    // A constant "last was 1" makes every tie resolve to requester 0.
    assign last_sel = 1'b1;
`endif

    always_comb begin
        we_sel  = win ? r1.we : r0.we;
        ram_ce  = gnt_any;
        ram_wre = gnt_any & we_sel;
        ram_ad  = '0;
        ram_din = '0;
        if (gnt_any) begin
            ram_ad  = win ? r1.addr  : r0.addr;
            ram_din = win ? r1.wdata : r0.wdata;
        end
        tag_d.valid = gnt_any & ~we_sel;
        tag_d.owner = win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q  <= '0;
`ifdef SP16K_ARB_RR_EN
            last_q <= 1'b1;
`endif
        end else begin
            tag_q  <= tag_d;
`ifdef SP16K_ARB_RR_EN
            last_q <= last_d;
`endif
        end
    end

    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

    assign r0.gnt = gnt_any & (win == 1'b0);
    assign r1.gnt = gnt_any & (win == 1'b1);

    // Reset in the return cycle still suppresses the pending read.
    assign r0.rvalid = tag_q.valid & (tag_q.owner == 1'b0) & ~reset;
    assign r1.rvalid = tag_q.valid & (tag_q.owner == 1'b1) & ~reset;
    assign r0.rdata  = ram_dout;
    assign r1.rdata  = ram_dout;

endmodule

// File: tb/tb_sp16k_arbiter.sv
// Directed vector bench for sp16k_arbiter with a behavioural bypass-mode SP16K RAM.
module tb_sp16k_arbiter;

    logic        clk;
    logic        rst;
    logic        ram_ce, ram_oce, ram_wre, ram_reset;
    logic [13:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [7:0]  mem [0:16383];

    int n_checks;
    int n_errors;

    sp16k_arbiter_if #(.ADDR_W(14), .DATA_W(8)) r0_if ();
    sp16k_arbiter_if #(.ADDR_W(14), .DATA_W(8)) r1_if ();

    sp16k_arbiter #(.ADDR_W(14), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (rst),
        .r0        (r0_if),
        .r1        (r1_if),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_wre   (ram_wre),
        .ram_reset (ram_reset),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bypass-mode RAM: read data appears the cycle after the read access.
    always @(posedge clk) begin
        if (ram_reset) ram_dout <= 8'h00;
        else if (ram_ce && !ram_wre) ram_dout <= mem[ram_ad];
        if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;
    end

    typedef struct {
        logic        rst;
        logic        q0, w0;
        logic [13:0] a0;
        logic [7:0]  d0;
        logic        q1, w1;
        logic [13:0] a1;
        logic [7:0]  d1;
        logic        g0, g1, wre;
        logic [13:0] ad;
        logic [7:0]  din;
        logic        v0, v1;
        logic [7:0]  rd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(
        input logic rst_i,
        input logic q0, input logic w0, input logic [13:0] a0, input logic [7:0] d0,
        input logic q1, input logic w1, input logic [13:0] a1, input logic [7:0] d1,
        input logic g0, input logic g1, input logic wre, input logic [13:0] ad,
        input logic [7:0] din, input logic v0, input logic v1, input logic [7:0] rd);
        vec_t r;
        r.rst = rst_i; r.q0 = q0; r.w0 = w0; r.a0 = a0; r.d0 = d0;
        r.q1 = q1; r.w1 = w1; r.a1 = a1; r.d1 = d1;
        r.g0 = g0; r.g1 = g1; r.wre = wre; r.ad = ad; r.din = din;
        r.v0 = v0; r.v1 = v1; r.rd = rd;
        return r;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst         = t.rst;
        r0_if.req   = t.q0; r0_if.we = t.w0; r0_if.addr = t.a0; r0_if.wdata = t.d0;
        r1_if.req   = t.q1; r1_if.we = t.w1; r1_if.addr = t.a1; r1_if.wdata = t.d1;
    endtask

    localparam logic [13:0] A0 = 14'h0123;
    localparam logic [13:0] A1 = 14'h3FFF;
    localparam logic [13:0] AZ = 14'h0000;

    int found;
    int exp_found;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        r0_if.req = 1'b0; r0_if.we = 1'b0; r0_if.addr = '0; r0_if.wdata = '0;
        r1_if.req = 1'b0; r1_if.we = 1'b0; r1_if.addr = '0; r1_if.wdata = '0;

        // reset masks requests, then r0 write/read round trip
        tv.push_back(v(1, 1,0,14'h0001,8'h00, 1,0,14'h0002,8'h00, 0,0,0,AZ,8'h00, 0,0,8'h00));
        tv.push_back(v(1, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 0,0,8'h00));
        tv.push_back(v(0, 1,1,A0,8'hA5,       0,0,AZ,8'h00,       1,0,1,A0,8'hA5, 0,0,8'h00));
        tv.push_back(v(0, 1,0,A0,8'h11,       0,0,AZ,8'h00,       1,0,0,A0,8'h11, 0,0,8'h00));
        tv.push_back(v(0, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 1,0,8'hA5));
        // r1 read then r0 write to same top address: read sees old data
        tv.push_back(v(0, 0,0,AZ,8'h00,       1,1,A1,8'h5A,       0,1,1,A1,8'h5A, 0,0,8'h00));
        tv.push_back(v(0, 0,0,AZ,8'h00,       1,0,A1,8'h22,       0,1,0,A1,8'h22, 0,0,8'h00));
        tv.push_back(v(0, 1,1,A1,8'hFF,       0,0,AZ,8'h00,       1,0,1,A1,8'hFF, 0,1,8'h5A));
        tv.push_back(v(0, 1,0,A1,8'h11,       0,0,AZ,8'h00,       1,0,0,A1,8'h11, 0,0,8'h00));
        tv.push_back(v(0, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 1,0,8'hFF));
        // reset, then both read continuously
        tv.push_back(v(1, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 0,0,8'h00));
`ifdef SP16K_ARB_RR_EN
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       1,0,0,A0,8'h11, 0,0,8'h00));
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       0,1,0,A1,8'h22, 1,0,8'hA5));
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       1,0,0,A0,8'h11, 0,1,8'hFF));
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       0,1,0,A1,8'h22, 1,0,8'hA5));
        tv.push_back(v(0, 0,0,AZ,8'h00,       1,0,A1,8'h22,       0,1,0,A1,8'h22, 0,1,8'hFF));
`else
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       1,0,0,A0,8'h11, 0,0,8'h00));
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       1,0,0,A0,8'h11, 1,0,8'hA5));
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       1,0,0,A0,8'h11, 1,0,8'hA5));
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       1,0,0,A0,8'h11, 1,0,8'hA5));
        tv.push_back(v(0, 0,0,AZ,8'h00,       1,0,A1,8'h22,       0,1,0,A1,8'h22, 1,0,8'hA5));
`endif
        tv.push_back(v(0, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 0,1,8'hFF));
        // reset right after a read grant cancels its rvalid; first tie goes to r0
        tv.push_back(v(0, 0,0,AZ,8'h00,       1,0,A1,8'h22,       0,1,0,A1,8'h22, 0,0,8'h00));
        tv.push_back(v(1, 1,0,A0,8'h11,       1,0,A1,8'h22,       0,0,0,AZ,8'h00, 0,0,8'h00));
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       1,0,0,A0,8'h11, 0,0,8'h00));
        tv.push_back(v(0, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 1,0,8'hA5));
        // address zero round trip through r1
        tv.push_back(v(0, 0,0,AZ,8'h00,       1,1,AZ,8'h3C,       0,1,1,AZ,8'h3C, 0,0,8'h00));
        tv.push_back(v(0, 0,0,AZ,8'h00,       1,0,AZ,8'h22,       0,1,0,AZ,8'h22, 0,0,8'h00));
        tv.push_back(v(0, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 0,1,8'h3C));
        // single r0 grant then tie: pointer effect differs between builds
        tv.push_back(v(0, 1,0,A0,8'h11,       0,0,AZ,8'h00,       1,0,0,A0,8'h11, 0,0,8'h00));
`ifdef SP16K_ARB_RR_EN
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       0,1,0,A1,8'h22, 1,0,8'hA5));
        tv.push_back(v(0, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 0,1,8'hFF));
`else
        tv.push_back(v(0, 1,0,A0,8'h11,       1,0,A1,8'h22,       1,0,0,A0,8'h11, 1,0,8'hA5));
        tv.push_back(v(0, 0,0,AZ,8'h00,       0,0,AZ,8'h00,       0,0,0,AZ,8'h00, 1,0,8'hA5));
`endif

        foreach (tv[i]) begin
            @(posedge clk);
            #1;
            drive(tv[i]);
            @(negedge clk);
            chk("r0_gnt",    i, 32'(r0_if.gnt),  32'(tv[i].g0));
            chk("r1_gnt",    i, 32'(r1_if.gnt),  32'(tv[i].g1));
            chk("gnt_mutex", i, 32'(r0_if.gnt & r1_if.gnt), 32'(0));
            chk("ram_ce",    i, 32'(ram_ce),     32'(tv[i].g0 | tv[i].g1));
            chk("ram_wre",   i, 32'(ram_wre),    32'(tv[i].wre));
            chk("ram_oce",   i, 32'(ram_oce),    32'(1));
            chk("ram_reset", i, 32'(ram_reset),  32'(tv[i].rst));
            if (tv[i].g0 || tv[i].g1 || tv[i].rst) begin
                chk("ram_ad",  i, 32'(ram_ad),  32'(tv[i].ad));
                chk("ram_din", i, 32'(ram_din), 32'(tv[i].din));
            end
            chk("r0_rvalid", i, 32'(r0_if.rvalid), 32'(tv[i].v0));
            chk("r1_rvalid", i, 32'(r1_if.rvalid), 32'(tv[i].v1));
            if (tv[i].v0) chk("r0_rdata", i, 32'(r0_if.rdata), 32'(tv[i].rd));
            if (tv[i].v1) chk("r1_rdata", i, 32'(r1_if.rdata), 32'(tv[i].rd));
        end

        // r1 held against r0 holding for three cycles: cycle of r1's first grant
`ifdef SP16K_ARB_RR_EN
        exp_found = 1;
`else
        exp_found = 3;
`endif
        found = -1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            r0_if.req = (c < 3); r0_if.we = 1'b0; r0_if.addr = A0; r0_if.wdata = 8'h11;
            r1_if.req = 1'b1;    r1_if.we = 1'b0; r1_if.addr = A1; r1_if.wdata = 8'h22;
            @(negedge clk);
            if (r1_if.gnt) begin
                found = c;
                break;
            end
        end
        chk("r1_first_gnt_cycle", 999, 32'(found), 32'(exp_found));

        @(posedge clk);
        #1;
        r0_if.req = 1'b0;
        r1_if.req = 1'b0;
        @(negedge clk);
        chk("r1_rvalid_after_hold", 1000, 32'(r1_if.rvalid), 32'(1));
        chk("r1_rdata_after_hold",  1000, 32'(r1_if.rdata),  32'(8'hFF));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
